out_port_fifo: RTL and testbench
================================

// Module: out_port_fifo
// PURPOSE
//   Output-port buffer for the MP-8 microprocessor, downstream of the processor top level.
//   - Captures each byte the processor writes: outToOutside, qualified by OutWrite.
//   - Holds up to DEPTH bytes in a FIFO.
//   - Drains them to an external consumer over a valid/ready handshake, so a slow sink
//     never stalls the processor.
//   - Flags bytes lost to a full buffer with a sticky overflow bit.
// PARAMETERS
//   DATA_W  8  width of each stored byte
//   DEPTH   4  number of FIFO entries; must be a power of 2, >= 2
//   ADDR_W  2  pointer width; must equal log2(DEPTH)
// PORTS
//   clk           in   1         system clock; all state changes on its rising edge
//   reset         in   1         synchronous, active-high reset
//   OutWrite      in   1         write strobe from the processor control unit
//   outToOutside  in   DATA_W    byte from the processor output register
//   out_data      out  DATA_W    head-of-FIFO byte presented to the consumer
//   out_valid     out  1         out_data holds a valid byte
//   out_ready     in   1         consumer accepts out_data this cycle
//   full          out  1         count == DEPTH
//   empty         out  1         count == 0
//   count         out  ADDR_W+1  number of bytes stored, 0..DEPTH
//   overflow      out  1         sticky: at least one write was dropped
//   clr_ovf       in   1         clears overflow
// BEHAVIOUR
//   Reset (reset=1 at a clk edge): all stored content is discarded, including mid-drain.
//     - After the edge: wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0, overflow=0,
//       out_valid=0, out_data=0.
//     - Reset has priority over every other input in that cycle.
//   Push: OutWrite is level-sensitive; every cycle it is high is one write attempt.
//     - A write is accepted when (!full || pop) in that cycle.
//     - Accepted: mem[wr_ptr] <= outToOutside; wr_ptr increments modulo DEPTH.
//   Pop: occurs when out_valid && out_ready.
//     - rd_ptr increments modulo DEPTH.
//     - The consumer samples out_data in the same cycle that pop occurs.
//   First-word-fall-through output.
//     - out_valid = !empty.
//     - out_data = mem[rd_ptr] when !empty, otherwise 0.
//     - Both outputs are decoded from registered state only; out_ready never feeds them.
//   Latency: a byte pushed at edge N is visible on out_data/out_valid after edge N.
//     It can be popped at edge N+1 at the earliest.
//   count update: count_next = count + push - pop. Never exceeds DEPTH; never wraps below 0.
//   Simultaneous events:
//     - Push and pop with 0 < count < DEPTH: count is unchanged; both pointers advance.
//     - Full, with OutWrite and pop in the same cycle: the write is accepted; count stays DEPTH.
//     - Empty, with OutWrite and out_ready: push only; no pop, since out_valid=0.
//   Overflow:
//     - A write is dropped when OutWrite=1, full=1 and there is no pop.
//     - The dropped byte is discarded; FIFO contents and pointers are unchanged.
//     - overflow is set after that edge.
//   Sticky flag:
//     - clr_ovf=1 clears overflow at the next edge.
//     - A drop in the same cycle as clr_ovf wins: overflow stays 1.
//   Pointer wrap: pointers are ADDR_W bits and wrap naturally.
//     - full and empty are decoded from count, never from pointer equality.
//   Out of range:
//     - out_ready when out_valid=0 is ignored.
//     - outToOutside is don't-care when OutWrite=0.
// TESTING (DEPTH=4)
//   1. Reset, then OutWrite pulse with 0x5A, out_ready=0.
//      -> after the edge: out_valid=1, out_data=0x5A, count=1, empty=0.
//      -> one cycle later with out_ready=1: count=0, out_valid=0, out_data=0.
//   2. Write 0x11,0x22,0x33,0x44 on back-to-back cycles, out_ready=0.
//      -> full=1, count=4.
//      -> fifth write 0x55: overflow=1, count=4.
//      -> drain with out_ready=1: reads 0x11,0x22,0x33,0x44; 0x55 is never output.
//   3. Full FIFO; OutWrite=1 with 0x99 and out_ready=1 in the same cycle.
//      -> head popped, 0x99 accepted, count stays 4, overflow stays 0.
//      -> 0x99 emerges as the fourth byte of the drain.
//   4. Continuous streaming with OutWrite=1 and out_ready=1 for 10 cycles, data 0x00..0x09.
//      -> count holds at 1 after the first edge.
//      -> outputs 0x00..0x09 in order; pointers wrap twice; no overflow.
//   5. overflow=1, then in the same cycle clr_ovf=1 and a dropped write (full, no pop).
//      -> overflow stays 1.
//      -> next cycle: clr_ovf=1, no write -> overflow=0.
//   6. Three bytes stored; assert reset for one cycle while out_ready=1.
//      -> count=0, out_valid=0, out_data=0, overflow=0.
//      -> the next write 0xC3 appears as the head byte.

Source files
------------

// File: rtl/out_port_fifo.sv
// Output-port FIFO for the MP-8: buffers processor output bytes and drains them over
// a first-word-fall-through valid/ready handshake, with a sticky overflow flag.
module out_port_fifo #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              OutWrite,
    input  logic [DATA_W-1:0] outToOutside,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    input  logic              clr_ovf
);

    localparam logic [ADDR_W:0] DepthCnt = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              overflow_q, overflow_d;
    logic              push, pop, drop;

    assign full      = (count_q == DepthCnt);
    assign empty     = (count_q == '0);
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign out_valid = !empty;
    assign out_data  = empty ? '0 : mem_q[rd_ptr_q];

    // A pop frees the head slot in the same cycle, so a full FIFO can still accept a write.
    assign pop  = out_valid && out_ready;
    assign push = OutWrite && (!full || pop);
    assign drop = OutWrite && full && !pop;

    always_comb begin
        wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
        if (drop) begin
            overflow_d = 1'b1;
        end else if (clr_ovf) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage needs no reset: out_data is forced to zero whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            mem_q[wr_ptr_q] <= outToOutside;
        end
    end

endmodule

// File: tb/tb_out_port_fifo.sv
// Self-checking bench for out_port_fifo: directed vector table, streaming sequence,
// and randomized traffic compared against a queue-based reference model.
module tb_out_port_fifo;

    logic       clk = 1'b0;
    logic       reset, OutWrite, out_ready, clr_ovf;
    logic [7:0] outToOutside, out_data;
    logic       out_valid, full, empty, overflow;
    logic [2:0] count;

    int checks = 0;
    int failures = 0;

    out_port_fifo #(.DATA_W(8), .DEPTH(4), .ADDR_W(2)) dut (
        .clk(clk),
        .reset(reset),
        .OutWrite(OutWrite),
        .outToOutside(outToOutside),
        .out_data(out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .full(full),
        .empty(empty),
        .count(count),
        .overflow(overflow),
        .clr_ovf(clr_ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       wr;
        logic [7:0] din;
        logic       rdy;
        logic       clr;
        logic       ev;
        logic [7:0] ed;
        logic [2:0] ec;
        logic       eo;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic rst, logic wr, logic [7:0] din, logic rdy, logic clr,
                                logic ev, logic [7:0] ed, logic [2:0] ec, logic eo);
        vec_t v;
        v.rst = rst; v.wr = wr; v.din = din; v.rdy = rdy; v.clr = clr;
        v.ev = ev; v.ed = ed; v.ec = ec; v.eo = eo;
        return v;
    endfunction

    task automatic chk(string name, int idx, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s step=%0d actual=%0h required=%0h", name, idx, act, exp);
        end
    endtask

    task automatic chk_all(int idx, logic ev, logic [7:0] ed, logic [2:0] ec, logic eo);
        chk("out_valid", idx, 32'(out_valid), 32'(ev));
        chk("out_data", idx, 32'(out_data), 32'(ed));
        chk("count", idx, 32'(count), 32'(ec));
        chk("full", idx, 32'(full), 32'(ec == 3'd4));
        chk("empty", idx, 32'(empty), 32'(ec == 3'd0));
        chk("overflow", idx, 32'(overflow), 32'(eo));
    endtask

    task automatic drive(logic rst, logic wr, logic [7:0] din, logic rdy, logic clr);
        reset = rst; OutWrite = wr; outToOutside = din; out_ready = rdy; clr_ovf = clr;
        @(posedge clk);
        #1;
    endtask

    logic [7:0] q[$];
    logic       m_ovf;

    initial begin
        reset = 1'b1; OutWrite = 1'b0; outToOutside = '0; out_ready = 1'b0; clr_ovf = 1'b0;

        //            rst wr din    rdy clr  ev ed     ec  eo
        tbl.push_back(mk(1, 0, 8'h00, 0, 0,  0, 8'h00, 0,  0));
        tbl.push_back(mk(0, 1, 8'h5A, 0, 0,  1, 8'h5A, 1,  0));
        tbl.push_back(mk(0, 0, 8'h00, 1, 0,  0, 8'h00, 0,  0));
        tbl.push_back(mk(0, 1, 8'h11, 0, 0,  1, 8'h11, 1,  0));
        tbl.push_back(mk(0, 1, 8'h22, 0, 0,  1, 8'h11, 2,  0));
        tbl.push_back(mk(0, 1, 8'h33, 0, 0,  1, 8'h11, 3,  0));
        tbl.push_back(mk(0, 1, 8'h44, 0, 0,  1, 8'h11, 4,  0));
        tbl.push_back(mk(0, 1, 8'h55, 0, 0,  1, 8'h11, 4,  1));
        tbl.push_back(mk(0, 0, 8'h00, 1, 0,  1, 8'h22, 3,  1));
        tbl.push_back(mk(0, 0, 8'h00, 1, 0,  1, 8'h33, 2,  1));
        tbl.push_back(mk(0, 0, 8'h00, 1, 0,  1, 8'h44, 1,  1));
        tbl.push_back(mk(0, 0, 8'h00, 1, 0,  0, 8'h00, 0,  1));
        tbl.push_back(mk(0, 0, 8'h00, 0, 1,  0, 8'h00, 0,  0));
        tbl.push_back(mk(0, 1, 8'hA1, 0, 0,  1, 8'hA1, 1,  0));
        tbl.push_back(mk(0, 1, 8'hA2, 0, 0,  1, 8'hA1, 2,  0));
        tbl.push_back(mk(0, 1, 8'hA3, 0, 0,  1, 8'hA1, 3,  0));
        tbl.push_back(mk(0, 1, 8'hA4, 0, 0,  1, 8'hA1, 4,  0));
        tbl.push_back(mk(0, 1, 8'h99, 1, 0,  1, 8'hA2, 4,  0));
        tbl.push_back(mk(0, 0, 8'h00, 1, 0,  1, 8'hA3, 3,  0));
        tbl.push_back(mk(0, 0, 8'h00, 1, 0,  1, 8'hA4, 2,  0));
        tbl.push_back(mk(0, 0, 8'h00, 1, 0,  1, 8'h99, 1,  0));
        tbl.push_back(mk(0, 0, 8'h00, 1, 0,  0, 8'h00, 0,  0));
        tbl.push_back(mk(0, 1, 8'hB0, 0, 0,  1, 8'hB0, 1,  0));
        tbl.push_back(mk(0, 1, 8'hB1, 0, 0,  1, 8'hB0, 2,  0));
        tbl.push_back(mk(0, 1, 8'hB2, 0, 0,  1, 8'hB0, 3,  0));
        tbl.push_back(mk(0, 1, 8'hB3, 0, 0,  1, 8'hB0, 4,  0));
        tbl.push_back(mk(0, 1, 8'hEE, 0, 0,  1, 8'hB0, 4,  1));
        tbl.push_back(mk(0, 1, 8'hEF, 0, 1,  1, 8'hB0, 4,  1));
        tbl.push_back(mk(0, 0, 8'h00, 0, 1,  1, 8'hB0, 4,  0));
        tbl.push_back(mk(0, 1, 8'hEE, 0, 0,  1, 8'hB0, 4,  1));
        tbl.push_back(mk(0, 0, 8'h00, 1, 0,  1, 8'hB1, 3,  1));
        tbl.push_back(mk(1, 1, 8'h7E, 1, 0,  0, 8'h00, 0,  0));
        tbl.push_back(mk(0, 1, 8'hC3, 0, 0,  1, 8'hC3, 1,  0));
        tbl.push_back(mk(0, 0, 8'h00, 1, 0,  0, 8'h00, 0,  0));
        tbl.push_back(mk(0, 1, 8'h77, 1, 0,  1, 8'h77, 1,  0));
        tbl.push_back(mk(0, 0, 8'h00, 1, 0,  0, 8'h00, 0,  0));

        @(negedge clk);
        foreach (tbl[i]) begin
            drive(tbl[i].rst, tbl[i].wr, tbl[i].din, tbl[i].rdy, tbl[i].clr);
            chk_all(i, tbl[i].ev, tbl[i].ed, tbl[i].ec, tbl[i].eo);
        end

        // Continuous streaming: one in, one out every cycle, pointers wrap.
        for (int i = 0; i < 10; i++) begin
            drive(0, 1, 8'(i), 1, 0);
            chk_all(100 + i, 1'b1, 8'(i), 3'd1, 1'b0);
        end
        drive(0, 0, 8'h00, 1, 0);
        chk_all(110, 1'b0, 8'h00, 3'd0, 1'b0);

        // Randomized traffic against a queue model.
        drive(1, 0, 8'h00, 0, 0);
        q.delete();
        m_ovf = 1'b0;
        chk_all(200, 1'b0, 8'h00, 3'd0, 1'b0);
        for (int n = 0; n < 600; n++) begin
            logic       r_rst, r_wr, r_rdy, r_clr, m_pop, m_push;
            logic [7:0] r_din;
            r_rst = ($urandom_range(0, 49) == 0);
            r_wr  = ($urandom_range(0, 99) < 60);
            r_rdy = ($urandom_range(0, 99) < 45);
            r_clr = ($urandom_range(0, 9) == 0);
            r_din = 8'($urandom);
            m_pop  = (q.size() > 0) && r_rdy;
            m_push = r_wr && ((q.size() < 4) || m_pop);
            if (r_rst) begin
                q.delete();
                m_ovf = 1'b0;
            end else begin
                if (m_pop) void'(q.pop_front());
                if (m_push) q.push_back(r_din);
                if (r_wr && !m_push) m_ovf = 1'b1;
                else if (r_clr) m_ovf = 1'b0;
            end
            drive(r_rst, r_wr, r_din, r_rdy, r_clr);
            chk_all(1000 + n, q.size() > 0, (q.size() > 0) ? q[0] : 8'h00,
                    3'(q.size()), m_ovf);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
